exu_alu_1: RTL and testbench

EXU_ALU_1 -- requirements
Module: exu_alu_1

---
 rtl/exu_alu_1.sv | 152 +++++++++++++++
 tb/tb_exu_alu_1.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_alu_1.sv
// exu_alu_1: single-cycle integer ALU with an in-order result buffer
// feeding the ROB fill port. Optional multiply: EXU_ALU_1_MUL_EN.
module exu_alu_1 #(
   parameter int DATA_W     = 32,
   parameter int ROB_IDX_W  = 6,
   parameter int OBUF_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 iss_valid,
   output logic                 iss_ready,
   input  logic [3:0]           iss_op,
   input  logic [ROB_IDX_W-1:0] iss_rob_idx,
   input  logic [DATA_W-1:0]    iss_src_a,
   input  logic [DATA_W-1:0]    iss_src_b,
   output logic                 fill_valid,
   input  logic                 fill_ready,
   output logic [ROB_IDX_W-1:0] fill_rob_idx,
   output logic [DATA_W-1:0]    fill_data,
   output logic                 fill_exc
);

   localparam int PTR_W = $clog2(OBUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
`ifdef EXU_ALU_1_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'd10;
`endif

   typedef struct packed {
      logic [ROB_IDX_W-1:0] tag;
      logic [DATA_W-1:0]    data;
      logic                 exc;
   } ent_t;

   logic                 e1_valid;
   logic [3:0]           e1_op;
   logic [ROB_IDX_W-1:0] e1_tag;
   logic [DATA_W-1:0]    e1_a;
   logic [DATA_W-1:0]    e1_b;

   logic [DATA_W-1:0]    e1_res;
   logic                 e1_exc;
   logic [4:0]           shamt;

   ent_t                 obuf [OBUF_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;

   logic                 iss_fire;
   logic                 fill_pop;
   logic [CNT_W:0]       occ;

   // Occupancy counts the E1 entry too, so every E1 result
   // is guaranteed a buffer slot on the following edge.
   assign fill_valid = (count != '0) & ~flush;
   assign fill_pop   = fill_valid & fill_ready;
   assign occ        = {1'b0, count}
                     + (CNT_W+1)'(e1_valid)
                     - (CNT_W+1)'(fill_pop);
   assign iss_ready  = rst_n & ~flush
                     & (occ < (CNT_W+1)'(OBUF_DEPTH));
   assign iss_fire   = iss_valid & iss_ready;

   assign fill_rob_idx = obuf[rd_ptr].tag;
   assign fill_data    = obuf[rd_ptr].data;
   assign fill_exc     = obuf[rd_ptr].exc;

   assign shamt = e1_b[4:0];

   // E1 capture of op, tag and operands on an issue transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e1_valid <= 1'b0;
         e1_op    <= '0;
         e1_tag   <= '0;
         e1_a     <= '0;
         e1_b     <= '0;
      end else begin
         e1_valid <= iss_fire & ~flush;
         if (iss_fire) begin
            e1_op  <= iss_op;
            e1_tag <= iss_rob_idx;
            e1_a   <= iss_src_a;
            e1_b   <= iss_src_b;
         end
      end
   end

   // Combinational ALU result from the E1 register
   always_comb begin
      e1_res = '0;
      e1_exc = 1'b0;
      case (e1_op)
         OP_ADD:  e1_res = e1_a + e1_b;
         OP_SUB:  e1_res = e1_a - e1_b;
         OP_AND:  e1_res = e1_a & e1_b;
         OP_OR:   e1_res = e1_a | e1_b;
         OP_XOR:  e1_res = e1_a ^ e1_b;
         OP_SLL:  e1_res = e1_a << shamt;
         OP_SRL:  e1_res = e1_a >> shamt;
         OP_SRA:  e1_res = $signed(e1_a) >>> shamt;
         OP_SLT:  e1_res = DATA_W'($signed(e1_a) < $signed(e1_b));
         OP_SLTU: e1_res = DATA_W'(e1_a < e1_b);
`ifdef EXU_ALU_1_MUL_EN
         OP_MUL:  e1_res = e1_a * e1_b;
`endif
         default: begin
            e1_res = '0;
            e1_exc = 1'b1;
         end
      endcase
   end

   // Result FIFO: push every valid E1 entry, pop on fill transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < OBUF_DEPTH; i++) begin
            obuf[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (e1_valid) begin
            obuf[wr_ptr] <= '{tag: e1_tag, data: e1_res, exc: e1_exc};
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (fill_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(e1_valid) - CNT_W'(fill_pop);
      end
   end

endmodule

// File: tb/tb_exu_alu_1.sv
// tb_exu_alu_1: directed and random checks of exu_alu_1 against
// an in-order queue model of the issue-to-fill path.
module tb_exu_alu_1;

   localparam int DW    = 32;
   localparam int TW    = 6;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          iss_valid;
   logic          iss_ready;
   logic [3:0]    iss_op;
   logic [TW-1:0] iss_rob_idx;
   logic [DW-1:0] iss_src_a;
   logic [DW-1:0] iss_src_b;
   logic          fill_valid;
   logic          fill_ready;
   logic [TW-1:0] fill_rob_idx;
   logic [DW-1:0] fill_data;
   logic          fill_exc;

   exu_alu_1 #(
      .DATA_W(DW), .ROB_IDX_W(TW), .OBUF_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_op(iss_op), .iss_rob_idx(iss_rob_idx),
      .iss_src_a(iss_src_a), .iss_src_b(iss_src_b),
      .fill_valid(fill_valid), .fill_ready(fill_ready),
      .fill_rob_idx(fill_rob_idx), .fill_data(fill_data),
      .fill_exc(fill_exc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
      logic          exc;
      int            age;
   } exp_t;

   exp_t q[$];
   int   nchk  = 0;
   int   nfail = 0;

   logic          last_fv;
   logic          last_rdy;
   logic [TW-1:0] last_tag;
   logic [DW-1:0] last_data;
   logic          last_exc;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void ref_alu(input logic [3:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [31:0] r,
                                   output logic e);
      int unsigned s;
      s = int'(b % 32);
      e = 1'b0;
      r = 32'd0;
      case (op)
         4'd0: r = 32'(longint'(a) + longint'(b));
         4'd1: r = 32'(longint'(a) - longint'(b));
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = 32'(longint'(a) * (longint'(1) << s));
         4'd6: r = 32'(longint'(a) / (longint'(1) << s));
         4'd7: begin
            r = a >> s;
            if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
         end
         4'd8: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd9: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
`ifdef EXU_ALU_1_MUL_EN
         4'd10: r = 32'(longint'(a) * longint'(b));
`endif
         default: begin
            r = 32'd0;
            e = 1'b1;
         end
      endcase
   endfunction

   // One clock cycle: drive, check against the model, advance the model.
   task automatic step(input logic iv, input logic [3:0] op,
                       input logic [TW-1:0] tag,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic fr, input logic fl);
      logic efv;
      logic pop;
      logic erdy;
      exp_t e;
      iss_valid   = iv;
      iss_op      = op;
      iss_rob_idx = tag;
      iss_src_a   = a;
      iss_src_b   = b;
      fill_ready  = fr;
      flush       = fl;
      #1;
      efv  = !fl && q.size() > 0 && q[0].age >= 1;
      pop  = efv && fr;
      erdy = !fl && ((q.size() - (pop ? 1 : 0)) < DEPTH);
      chk("fill_valid", 64'(fill_valid), 64'(efv));
      chk("iss_ready", 64'(iss_ready), 64'(erdy));
      if (efv && fill_valid) begin
         chk("fill_rob_idx", 64'(fill_rob_idx), 64'(q[0].tag));
         chk("fill_data", 64'(fill_data), 64'(q[0].data));
         chk("fill_exc", 64'(fill_exc), 64'(q[0].exc));
      end
      last_fv   = fill_valid;
      last_rdy  = iss_ready;
      last_tag  = fill_rob_idx;
      last_data = fill_data;
      last_exc  = fill_exc;
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         foreach (q[i]) q[i].age++;
         if (iv && erdy) begin
            e.tag = tag;
            e.age = 0;
            ref_alu(op, a, b, e.data, e.exc);
            q.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic fr);
      step(1'b0, 4'd0, '0, 32'd0, 32'd0, fr, 1'b0);
   endtask

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rst_n = 1'b0;
      flush = 1'b0;
      iss_valid = 1'b0;
      iss_op = '0;
      iss_rob_idx = '0;
      iss_src_a = '0;
      iss_src_b = '0;
      fill_ready = 1'b0;
      #3;
      chk("rst_fill_valid", 64'(fill_valid), 64'd0);
      chk("rst_iss_ready", 64'(iss_ready), 64'd0);
      chk("rst_fill_tag", 64'(fill_rob_idx), 64'd0);
      chk("rst_fill_data", 64'(fill_data), 64'd0);
      chk("rst_fill_exc", 64'(fill_exc), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 64'(iss_ready), 64'd1);

      // back-to-back ADD / SUB
      step(1'b1, 4'd0, 6'd3, 32'd5, 32'd7, 1'b1, 1'b0);
      step(1'b1, 4'd1, 6'd4, 32'd5, 32'd7, 1'b1, 1'b0);
      idle(1'b1);
      chk("b2b_add_valid", 64'(last_fv), 64'd1);
      chk("b2b_add_tag", 64'(last_tag), 64'd3);
      chk("b2b_add_data", 64'(last_data), 64'h0000_000C);
      idle(1'b1);
      chk("b2b_sub_tag", 64'(last_tag), 64'd4);
      chk("b2b_sub_data", 64'(last_data), 64'hFFFF_FFFE);
      idle(1'b1);
      chk("b2b_empty", 64'(last_fv), 64'd0);

      // backpressure
      step(1'b1, 4'd7, 6'd10, 32'h8000_0000, 32'd4, 1'b0, 1'b0);
      step(1'b1, 4'd8, 6'd11, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
      step(1'b1, 4'd9, 6'd12, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
      chk("bp_third_blocked", 64'(last_rdy), 64'd0);
      step(1'b1, 4'd9, 6'd12, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
      chk("bp_full_ready", 64'(last_rdy), 64'd0);
      chk("bp_hold_data", 64'(last_data), 64'hF800_0000);
      step(1'b1, 4'd9, 6'd12, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
      chk("bp_sra", 64'(last_data), 64'hF800_0000);
      chk("bp_accept3", 64'(last_rdy), 64'd1);
      idle(1'b1);
      chk("bp_slt", 64'(last_data), 64'd1);
      idle(1'b1);
      chk("bp_sltu", 64'(last_data), 64'd0);
      chk("bp_sltu_tag", 64'(last_tag), 64'd12);
      idle(1'b1);

      // illegal opcodes
      step(1'b1, 4'd15, 6'd9, 32'd1, 32'd2, 1'b1, 1'b0);
      step(1'b1, 4'd10, 6'd13, 32'd6, 32'd7, 1'b1, 1'b0);
      idle(1'b1);
      chk("ill_exc", 64'(last_exc), 64'd1);
      chk("ill_data", 64'(last_data), 64'd0);
      chk("ill_tag", 64'(last_tag), 64'd9);
      idle(1'b1);
`ifdef EXU_ALU_1_MUL_EN
      chk("mul_data", 64'(last_data), 64'd42);
      chk("mul_exc", 64'(last_exc), 64'd0);
`else
      chk("op10_exc", 64'(last_exc), 64'd1);
      chk("op10_data", 64'(last_data), 64'd0);
`endif
      idle(1'b1);

      // flush with buffer full, then with E1 valid
      step(1'b1, 4'd0, 6'd20, 32'd1, 32'd1, 1'b0, 1'b0);
      step(1'b1, 4'd0, 6'd21, 32'd2, 32'd2, 1'b0, 1'b0);
      idle(1'b0);
      step(1'b1, 4'd0, 6'd22, 32'd3, 32'd3, 1'b1, 1'b1);
      chk("flush_fv", 64'(last_fv), 64'd0);
      idle(1'b1);
      chk("flush_fv_next", 64'(last_fv), 64'd0);
      step(1'b1, 4'd0, 6'd23, 32'd4, 32'd4, 1'b1, 1'b0);
      step(1'b1, 4'd0, 6'd24, 32'd5, 32'd5, 1'b1, 1'b1);
      step(1'b1, 4'd0, 6'd25, 32'd6, 32'd6, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      chk("flush_first_tag", 64'(last_tag), 64'd25);
      chk("flush_first_data", 64'(last_data), 64'd12);
      idle(1'b1);

      // asynchronous reset with two buffered results
      step(1'b1, 4'd2, 6'd30, 32'hF0F0, 32'hFF00, 1'b0, 1'b0);
      step(1'b1, 4'd3, 6'd31, 32'hF0F0, 32'hFF00, 1'b0, 1'b0);
      idle(1'b0);
      fill_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_fv", 64'(fill_valid), 64'd0);
      chk("arst_ready", 64'(iss_ready), 64'd0);
      chk("arst_data", 64'(fill_data), 64'd0);
      @(posedge clk);
      #1;
      chk("arst_fv_edge", 64'(fill_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      #1;
      chk("arst_release_ready", 64'(iss_ready), 64'd1);
      idle(1'b1);
      idle(1'b1);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(0, 9));
         ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         step(1'($urandom_range(0, 1)), rop, 6'($urandom), ra, rb,
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 99) < 3));
      end
      for (int n = 0; n < 4; n++) idle(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
